// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern controller: opcodes, mode encoding,
// handshake states and the default power-up pattern.
package led_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_LOAD      = 3'd1;
  localparam logic [2:0] OP_SET_MODE  = 3'd2;
  localparam logic [2:0] OP_SET_SPEED = 3'd3;
  localparam logic [2:0] OP_STEP      = 3'd4;
  localparam logic [2:0] OP_RESTORE   = 3'd5;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_APPLY = 1'b1
  } hs_state_e;

  localparam logic [7:0] DEFAULT_PATTERN = 8'h1F;
  localparam logic [2:0] BOUNCE_LAST     = 3'd7;

  // Ops that restart the step period from the APPLY edge.
  function automatic logic is_clearing_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_SET_MODE) ||
           (op == OP_SET_SPEED) || (op == OP_RESTORE);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler plus step counter: emits a one-cycle step every
// (speed+1)*CLK_DIV cycles, restartable with a synchronous clear.
module led_tick_gen #(
  parameter int unsigned CLK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] speed,
  input  logic       clear,
  output logic       step
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [7:0]    step_cnt_q;
  logic          base_tick;

  assign base_tick = (presc_q == PRESC_LAST);
  assign step      = base_tick && (step_cnt_q == speed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      step_cnt_q <= '0;
    end else if (clear) begin
      presc_q    <= '0;
      step_cnt_q <= '0;
    end else if (base_tick) begin
      presc_q    <= '0;
      step_cnt_q <= (step_cnt_q == speed) ? 8'd0 : step_cnt_q + 8'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Command-driven LED pattern sequencer: valid/ready command intake with a
// two-state IDLE/APPLY handshake, periodic rotate/bounce of the pattern register.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 25_000_000,
  parameter logic [7:0]  RESET_PATTERN = DEFAULT_PATTERN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] leds,
  output logic [1:0] mode,
  output logic       step_pulse
);

  hs_state_e  state_q;
  logic       ready_q;
  logic [2:0] op_q;
  logic [7:0] data_q;
  logic [7:0] leds_q, leds_d;
  mode_e      mode_q;
  logic [7:0] speed_q;
  logic       dir_right_q, dir_right_d;
  logic [2:0] pos_q, pos_d;
  logic       step_pulse_q;
  logic       step, tick_clear;
  logic [7:0] rot_left, rot_right;

  assign cmd_ready  = ready_q;
  assign leds       = leds_q;
  assign mode       = mode_q;
  assign step_pulse = step_pulse_q;

  assign tick_clear = (state_q == ST_APPLY) && is_clearing_op(op_q);

  led_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .speed (speed_q),
    .clear (tick_clear),
    .step  (step)
  );

  assign rot_left  = {leds_q[6:0], leds_q[7]};
  assign rot_right = {leds_q[0], leds_q[7:1]};

  always_comb begin
    leds_d      = leds_q;
    dir_right_d = dir_right_q;
    pos_d       = pos_q;
    case (mode_q)
      MODE_LEFT:  leds_d = rot_left;
      MODE_RIGHT: leds_d = rot_right;
      MODE_BOUNCE: begin
        leds_d = dir_right_q ? rot_right : rot_left;
        // Reaching the far end reverses direction for the next sweep.
        if (pos_q == BOUNCE_LAST - 3'd1) begin
          pos_d       = '0;
          dir_right_d = ~dir_right_q;
        end else begin
          pos_d = pos_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      op_q         <= OP_NOP;
      data_q       <= '0;
      leds_q       <= RESET_PATTERN;
      mode_q       <= MODE_LEFT;
      speed_q      <= '0;
      dir_right_q  <= 1'b0;
      pos_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      step_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            state_q <= ST_APPLY;
            ready_q <= 1'b0;
          end
          if (step && (mode_q != MODE_STOP)) begin
            leds_q       <= leds_d;
            pos_q        <= pos_d;
            dir_right_q  <= dir_right_d;
            step_pulse_q <= 1'b1;
          end
        end
        ST_APPLY: begin
          // Any periodic step coinciding with APPLY is dropped in favour of the command.
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          case (op_q)
            OP_LOAD: begin
              leds_q <= data_q;
              pos_q  <= '0;
            end
            OP_SET_MODE: begin
              mode_q      <= mode_e'(data_q[1:0]);
              pos_q       <= '0;
              dir_right_q <= 1'b0;
            end
            OP_SET_SPEED: speed_q <= data_q;
            OP_STEP: begin
              if (mode_q == MODE_STOP) begin
                leds_q       <= rot_left;
                step_pulse_q <= 1'b1;
              end
            end
            OP_RESTORE: begin
              leds_q <= RESET_PATTERN;
              pos_q  <= '0;
            end
            default: ;
          endcase
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl with CLK_DIV = 4: expected step patterns
// are queued as stimulus is issued and popped on each step_pulse.
module tb_led_pattern_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       step_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int apply_cyc;
  bit sb_on = 1'b0;
  logic [7:0] exp_q[$];
  int pulse_cyc[$];

  led_pattern_ctrl #(.CLK_DIV(4), .RESET_PATTERN(8'h1F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .leds       (leds),
    .mode       (mode),
    .step_pulse (step_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Scoreboard: every observed step_pulse consumes one expected pattern.
  always @(negedge clk) begin
    if (sb_on && step_pulse === 1'b1) begin
      pulse_cyc.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL step_unexpected: leds=%02h with no step expected (cyc %0d)", leds, cyc);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (leds !== e) begin
          bad++;
          $display("FAIL step_leds: got %02h expected %02h (cyc %0d)", leds, e, cyc);
        end else begin
          $display("step ok: leds=%02h cyc=%0d", leds, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    sb_on     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'h00;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    pulse_cyc.delete();
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] data);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd op=%0d data=%02h accepted at cyc %0d", op, data, cyc);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d expected steps outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (leds !== 8'h1F) begin bad++; $display("FAIL reset_leds: got %02h expected 1f", leds); end
    total++;
    if (mode !== 2'd1) begin bad++; $display("FAIL reset_mode: got %0d expected 1", mode); end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
    total++;
    if (step_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse: got %b expected 0", step_pulse); end
    $display("reset: leds=%02h mode=%0d ready=%b", leds, mode, cmd_ready);
    exp_q.push_back(8'h3E);
    exp_q.push_back(8'h7C);
    exp_q.push_back(8'hF8);
    exp_q.push_back(8'hF1);
    sb_on = 1'b1;
    drain(40);
    sb_on = 1'b0;
  endtask

  task automatic test_load_right();
    do_reset();
    sb_on = 1'b1;
    send_cmd(3'd1, 8'h81);
    @(negedge clk);
    total++;
    if (leds !== 8'h81) begin bad++; $display("FAIL load_leds: got %02h expected 81", leds); end
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'h60);
    send_cmd(3'd2, 8'h02);
    @(negedge clk);
    total++;
    if (mode !== 2'd2) begin bad++; $display("FAIL set_mode_right: got %0d expected 2", mode); end
    drain(40);
    total++;
    if (pulse_cyc.size() != 2 || pulse_cyc[1] - pulse_cyc[0] != 4) begin
      bad++;
      $display("FAIL right_step_gap: pulses=%0d gap not 4", pulse_cyc.size());
    end
    sb_on = 1'b0;
  endtask

  task automatic test_speed();
    do_reset();
    sb_on = 1'b1;
    send_cmd(3'd3, 8'd2);
    @(negedge clk);
    apply_cyc = cyc;
    exp_q.push_back(8'h3E);
    exp_q.push_back(8'h7C);
    drain(60);
    total++;
    if (pulse_cyc.size() != 2 || pulse_cyc[0] - apply_cyc != 12 || pulse_cyc[1] - pulse_cyc[0] != 12) begin
      bad++;
      $display("FAIL speed_period: pulses=%0d first_off=%0d expected 2 pulses at 12,12",
               pulse_cyc.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] - apply_cyc : -1);
    end
    repeat (3) @(negedge clk);
    pulse_cyc.delete();
    send_cmd(3'd3, 8'd2);
    @(negedge clk);
    apply_cyc = cyc;
    exp_q.push_back(8'hF8);
    drain(40);
    total++;
    if (pulse_cyc.size() != 1 || pulse_cyc[0] - apply_cyc != 12) begin
      bad++;
      $display("FAIL speed_midperiod: pulses=%0d offset=%0d expected 1 at 12",
               pulse_cyc.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] - apply_cyc : -1);
    end
    sb_on = 1'b0;
  endtask

  task automatic test_bounce();
    logic [7:0] p;
    do_reset();
    sb_on = 1'b1;
    send_cmd(3'd1, 8'h01);
    @(negedge clk);
    p = 8'h01;
    for (int i = 0; i < 7; i++) begin p = {p[6:0], p[7]}; exp_q.push_back(p); end
    for (int i = 0; i < 7; i++) begin p = {p[0], p[7:1]}; exp_q.push_back(p); end
    exp_q.push_back(8'h02);
    send_cmd(3'd2, 8'h03);
    @(negedge clk);
    total++;
    if (mode !== 2'd3) begin bad++; $display("FAIL set_mode_bounce: got %0d expected 3", mode); end
    drain(100);
    sb_on = 1'b0;
  endtask

  task automatic test_stop_step();
    do_reset();
    sb_on = 1'b1;
    send_cmd(3'd2, 8'h00);
    @(negedge clk);
    total++;
    if (mode !== 2'd0 || leds !== 8'h1F) begin
      bad++;
      $display("FAIL set_mode_stop: mode=%0d leds=%02h expected 0/1f", mode, leds);
    end
    exp_q.push_back(8'h3E);
    send_cmd(3'd4, 8'h00);
    @(negedge clk);
    total++;
    if (leds !== 8'h3E) begin bad++; $display("FAIL stop_step_leds: got %02h expected 3e", leds); end
    repeat (12) @(negedge clk);
    total++;
    if (leds !== 8'h3E) begin bad++; $display("FAIL stop_hold: got %02h expected 3e", leds); end
    exp_q.push_back(8'h7C);
    send_cmd(3'd2, 8'h01);
    send_cmd(3'd4, 8'h00);
    total++;
    if (mode !== 2'd1) begin bad++; $display("FAIL set_mode_left: got %0d expected 1", mode); end
    @(negedge clk);
    total++;
    if (leds !== 8'h3E) begin bad++; $display("FAIL step_in_left_noop: got %02h expected 3e", leds); end
    drain(20);
    sb_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    int accepted = 0;
    do_reset();
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    for (int i = 0; i < 4; i++) begin
      cmd_data = 8'hA0 + 8'(i);
      exp_rdy  = (i % 2 == 0);
      total++;
      if (cmd_ready !== exp_rdy) begin
        bad++;
        $display("FAIL b2b_ready[%0d]: got %b expected %b", i, cmd_ready, exp_rdy);
      end
      if (cmd_ready === 1'b1) accepted++;
      @(negedge clk);
      if (i == 1) begin
        total++;
        if (leds !== 8'hA0) begin bad++; $display("FAIL b2b_first: got %02h expected a0", leds); end
      end
    end
    cmd_valid = 1'b0;
    total++;
    if (accepted != 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", accepted); end
    total++;
    if (leds !== 8'hA2) begin bad++; $display("FAIL b2b_second: got %02h expected a2", leds); end
    $display("back_to_back: accepted=%0d leds=%02h", accepted, leds);
  endtask

  task automatic test_reset_in_apply();
    do_reset();
    send_cmd(3'd2, 8'h02);
    send_cmd(3'd1, 8'h55);
    rst_n = 1'b0;
    #1;
    total++;
    if (leds !== 8'h1F || mode !== 2'd1 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_apply_async: leds=%02h mode=%0d ready=%b expected 1f/1/1", leds, mode, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (leds !== 8'h1F || mode !== 2'd1) begin
      bad++;
      $display("FAIL rst_apply_lost: leds=%02h mode=%0d expected 1f/1", leds, mode);
    end
    $display("reset_in_apply: leds=%02h mode=%0d", leds, mode);
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 8'h00;
    test_reset();
    test_load_right();
    test_speed();
    test_bounce();
    test_stop_step();
    test_back_to_back();
    test_reset_in_apply();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
